wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage of the five-stage MIPS pipeline: the M/W pipeline register plus load-data extension and write-data selection, driving the register file's write port (A3, WD, WE, PC) directly. Captures the memory-stage bundle each clock, aligns and extends load data, and selects the result source. Checks load alignment and counts retired instructions. Also exports the W-stage destination and data to the forwarding network.

## Interface
- RESET_PC, 32'h0000_3000, value of pc_w and of the PC field after reset
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high; clears every register in the block
- valid_m  in  1  M-stage slot holds a real instruction
- bubble  in  1  force a nop into W on this edge (overrides valid_m)
- pc_m  in  32  PC of the M-stage instruction
- we_m  in  1  instruction writes a GPR
- a3_m  in  5  destination register
- wd_sel_m  in  2  result source: 0 ALU, 1 MEM, 2 PC+8, 3 HILO
- ld_type_m  in  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU; 5–7 treated as LW
- addr_lo_m  in  2  low two bits of the load address
- alu_m  in  32  ALU result
- mem_m  in  32  raw word read from data memory
- hilo_m  in  32  HI or LO value selected upstream
- we_w  out  1  regfile write enable
- a3_w  out  5  regfile write address
- wd_w  out  32  regfile write data
- pc_w  out  32  PC of the W-stage instruction, for the regfile trace
- exc_w  out  1  misaligned load currently in W
- retired_cnt  out  32  instructions retired since reset

## Operation
- On each posedge, if bubble is 1 or valid_m is 0, the stage captures a nop: valid 0, we 0, a3 0; the data fields may hold any value. Otherwise all M-stage fields are captured.
- The W-stage fields are held in registers. All outputs are combinational functions of those registered fields.
- Load extension is little-endian:
  - LB/LBU take the byte at mem[8*addr_lo+7 : 8*addr_lo]; LB sign-extends, LBU zero-extends.
  - LH/LHU take mem[31:16] when addr_lo[1]=1, else mem[15:0]; LH sign-extends, LHU zero-extends.
  - LW passes the word unchanged.
- Misalignment applies only when wd_sel=1:
  - LW with addr_lo≠0, or LH/LHU with addr_lo[0]=1, gives exc_w=1.
  - Byte loads never fault.
- wd_w mux:
  - sel 0: ALU result.
  - sel 1: extended load data.
  - sel 2: pc+8, computed modulo 2^32.
  - sel 3: HILO value.
- we_w = valid & we & (a3≠0) & ~exc_w. A write to $0 never reaches the regfile.
- a3_w and wd_w are driven even when we_w=0. Consumers qualify them with we_w.
- retired_cnt increments by 1 on each posedge where the registered slot has valid=1 and exc_w=0. It wraps from 0xFFFF_FFFF to 0.
- The fault policy is to suppress the write and report. Redirecting the PC is the exception unit's job.

## Timing
- Latency: M-stage inputs sampled at edge N appear on the W outputs after edge N. The regfile commits at edge N+1.
- No stall input; W never holds. Back-to-back instructions retire one per cycle.
- Reset, asynchronous, gives immediately:
  - valid 0, we_w 0, a3_w 0, wd_w 0, exc_w 0.
  - pc_w RESET_PC, retired_cnt 0.
- Reset asserted mid-instruction discards the W slot. No write is issued, and the counter is not incremented for that slot.
- Release of reset is synchronous to clk; the first capture happens on the first posedge with reset low.
- bubble and valid_m=1 on the same edge: bubble wins, and the instruction is dropped.
- Forwarding uses a3_w/wd_w/we_w in the same cycle (W→D/E bypass); no extra register.

## Structure
- Shared package mips_defs holds:
  - the WD_SEL_* constants (ALU/MEM/PC8/HILO);
  - the LD_* encodings (LW/LB/LBU/LH/LHU);
  - RESET_PC_DEFAULT, which is also used by the fetch stage.
- One combinational sub-module, load_ext: inputs mem word, addr_lo, ld_type; outputs extended data and misalign flag. It is reused by the memory-stage exception check.
- The top level contains only the pipeline register, the result mux, the write-enable logic and the counter.

## Test plan
- Reset → release, no instructions: we_w=0, pc_w=0x0000_3000, retired_cnt=0.
- ALU write to $5 with alu_m=0x1234_5678, pc_m=0x3004, sel 0: one cycle later we_w=1, a3_w=5, wd_w=0x1234_5678, pc_w=0x3004; retired_cnt becomes 1 on the next edge.
- Load extension, with mem_m=0x80FF_7F01:
  - LB addr_lo=3 → 0xFFFF_FF80.
  - LBU addr_lo=2 → 0x0000_00FF.
  - LH addr_lo=2 → 0xFFFF_80FF.
  - LHU addr_lo=0 → 0x0000_7F01.
- Misalignment: LW addr_lo=2 → exc_w=1, we_w=0, counter unchanged. LH addr_lo=1 behaves the same.
- JAL-style write:
  - pc_m=0x3010, sel 2, a3=31 → wd_w=0x3018, we_w=1.
  - pc_m=0xFFFF_FFFC → wd_w=0x0000_0004.
- Suppression cases:
  - Write to $0 → we_w=0, yet retired_cnt still increments.
  - bubble=1 with valid_m=1 → we_w=0, counter unchanged.
  - reset pulsed mid-cycle while a write is pending → we_w drops to 0 immediately.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared MIPS pipeline encodings used by the write-back stage
package mips_defs;

  localparam logic [1:0] WD_SEL_ALU  = 2'd0;
  localparam logic [1:0] WD_SEL_MEM  = 2'd1;
  localparam logic [1:0] WD_SEL_PC8  = 2'd2;
  localparam logic [1:0] WD_SEL_HILO = 2'd3;

  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - M-stage bundle in, regfile write port and status out
interface wb_stage_if;
  logic        valid_m;
  logic        bubble;
  logic [31:0] pc_m;
  logic        we_m;
  logic [4:0]  a3_m;
  logic [1:0]  wd_sel_m;
  logic [2:0]  ld_type_m;
  logic [1:0]  addr_lo_m;
  logic [31:0] alu_m;
  logic [31:0] mem_m;
  logic [31:0] hilo_m;

  logic        we_w;
  logic [4:0]  a3_w;
  logic [31:0] wd_w;
  logic [31:0] pc_w;
  logic        exc_w;
  logic [31:0] retired_cnt;

  modport master (
    output valid_m, bubble, pc_m, we_m, a3_m, wd_sel_m, ld_type_m, addr_lo_m,
           alu_m, mem_m, hilo_m,
    input  we_w, a3_w, wd_w, pc_w, exc_w, retired_cnt
  );

  modport slave (
    input  valid_m, bubble, pc_m, we_m, a3_m, wd_sel_m, ld_type_m, addr_lo_m,
           alu_m, mem_m, hilo_m,
    output we_w, a3_w, wd_w, pc_w, exc_w, retired_cnt
  );
endinterface

// File: rtl/wb_stage_load_ext.sv
// rtl/wb_stage_load_ext.sv - little-endian load alignment/extension and misalignment detect
module load_ext
  import mips_defs::*;
(
  input  logic [31:0] mem,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  ld_type,
  output logic [31:0] data,
  output logic        misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = mem[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? mem[31:16] : mem[15:0];
    data     = mem;
    misalign = 1'b0;
    case (ld_type)
      LD_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU: data = {24'd0, byte_sel};
      LD_LH: begin
        data     = {{16{half_sel[15]}}, half_sel};
        misalign = addr_lo[0];
      end
      LD_LHU: begin
        data     = {16'd0, half_sel};
        misalign = addr_lo[0];
      end
      // LW and the unused encodings 5-7 behave as a full-word load
      default: begin
        data     = mem;
        misalign = (addr_lo != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - M/W pipeline register, result mux, regfile write enable, retire counter
module wb_stage
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic      clk,
  input  logic      reset,
  wb_stage_if.slave bus
);

  logic        valid_r;
  logic        we_r;
  logic [4:0]  a3_r;
  logic [1:0]  sel_r;
  logic [2:0]  ld_r;
  logic [1:0]  lo_r;
  logic [31:0] pc_r;
  logic [31:0] alu_r;
  logic [31:0] mem_r;
  logic [31:0] hilo_r;
  logic [31:0] cnt_r;

  logic        capture;
  logic [31:0] ld_data;
  logic        ld_misalign;
  logic        exc;

  assign capture = bus.valid_m & ~bus.bubble;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= 1'b0;
      we_r    <= 1'b0;
      a3_r    <= 5'd0;
      sel_r   <= WD_SEL_ALU;
      ld_r    <= LD_LW;
      lo_r    <= 2'd0;
      pc_r    <= RESET_PC;
      alu_r   <= 32'd0;
      mem_r   <= 32'd0;
      hilo_r  <= 32'd0;
      cnt_r   <= 32'd0;
    end else begin
      valid_r <= capture;
      we_r    <= capture & bus.we_m;
      a3_r    <= capture ? bus.a3_m : 5'd0;
      // A nop selects ALU so it can never raise a misalignment fault
      sel_r   <= capture ? bus.wd_sel_m : WD_SEL_ALU;
      ld_r    <= bus.ld_type_m;
      lo_r    <= bus.addr_lo_m;
      if (capture) pc_r <= bus.pc_m;
      alu_r   <= bus.alu_m;
      mem_r   <= bus.mem_m;
      hilo_r  <= bus.hilo_m;
      if (valid_r & ~exc) cnt_r <= cnt_r + 32'd1;
    end
  end

  load_ext u_load_ext (
    .mem      (mem_r),
    .addr_lo  (lo_r),
    .ld_type  (ld_r),
    .data     (ld_data),
    .misalign (ld_misalign)
  );

  assign exc = valid_r & (sel_r == WD_SEL_MEM) & ld_misalign;

  always_comb begin
    bus.wd_w = alu_r;
    case (sel_r)
      WD_SEL_MEM:  bus.wd_w = ld_data;
      WD_SEL_PC8:  bus.wd_w = pc_r + 32'd8;
      WD_SEL_HILO: bus.wd_w = hilo_r;
      default:     bus.wd_w = alu_r;
    endcase
  end

  assign bus.we_w        = valid_r & we_r & (a3_r != 5'd0) & ~exc;
  assign bus.a3_w        = a3_r;
  assign bus.pc_w        = pc_r;
  assign bus.exc_w       = exc;
  assign bus.retired_cnt = cnt_r;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard bench for wb_stage with directed vectors
module tb_wb_stage;

  localparam logic [31:0] MEM_WORD  = 32'h80FF_7F01;
  localparam logic [31:0] HILO_WORD = 32'hCAFE_BABE;

  logic clk;
  logic reset;
  wb_stage_if bus ();

  wb_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          id;
    int          due;
    logic        valid;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
    logic        exc;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic [31:0] model_cnt = 32'd0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input int id, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s vec%0d: got %h expected %h", nm, id, act, exp);
  endfunction

  task automatic issue(input int id, input logic v, input logic bub, input logic [31:0] pc,
                       input logic we, input logic [4:0] a3, input logic [1:0] sel,
                       input logic [2:0] ld, input logic [1:0] lo, input logic [31:0] alu,
                       input logic ex_we, input logic [31:0] ex_wd, input logic ex_exc);
    exp_t e;
    @(posedge clk);
    #1;
    bus.valid_m   = v;
    bus.bubble    = bub;
    bus.pc_m      = pc;
    bus.we_m      = we;
    bus.a3_m      = a3;
    bus.wd_sel_m  = sel;
    bus.ld_type_m = ld;
    bus.addr_lo_m = lo;
    bus.alu_m     = alu;
    bus.mem_m     = MEM_WORD;
    bus.hilo_m    = HILO_WORD;
    e.id    = id;
    e.due   = cyc + 1;
    e.valid = v & ~bub;
    e.we    = ex_we;
    e.a3    = e.valid ? a3 : 5'd0;
    e.wd    = ex_wd;
    e.pc    = pc;
    e.exc   = ex_exc;
    e.cnt   = model_cnt;
    sb.push_back(e);
    if (e.valid && !ex_exc) model_cnt = model_cnt + 32'd1;
  endtask

  task automatic nop(input int id);
    issue(id, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  // Monitor: compare every scheduled expectation in the cycle it falls due
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        if (e.due < cyc) begin
          chk("late_entry", e.id, 32'(e.due), 32'(cyc));
        end else begin
          chk("we_w", e.id, 32'(bus.we_w), 32'(e.we));
          chk("a3_w", e.id, 32'(bus.a3_w), 32'(e.a3));
          chk("exc_w", e.id, 32'(bus.exc_w), 32'(e.exc));
          chk("retired_cnt", e.id, bus.retired_cnt, e.cnt);
          if (e.valid) begin
            chk("wd_w", e.id, bus.wd_w, e.wd);
            chk("pc_w", e.id, bus.pc_w, e.pc);
          end
        end
      end
    end
  end

  initial begin
    reset         = 1'b1;
    bus.valid_m   = 1'b0;
    bus.bubble    = 1'b0;
    bus.pc_m      = 32'h0;
    bus.we_m      = 1'b0;
    bus.a3_m      = 5'd0;
    bus.wd_sel_m  = 2'd0;
    bus.ld_type_m = 3'd0;
    bus.addr_lo_m = 2'd0;
    bus.alu_m     = 32'h0;
    bus.mem_m     = 32'h0;
    bus.hilo_m    = 32'h0;
    #3;
    chk("rst_we", 0, 32'(bus.we_w), 32'h0);
    chk("rst_a3", 0, 32'(bus.a3_w), 32'h0);
    chk("rst_wd", 0, bus.wd_w, 32'h0);
    chk("rst_exc", 0, 32'(bus.exc_w), 32'h0);
    chk("rst_pc", 0, bus.pc_w, 32'h0000_3000);
    chk("rst_cnt", 0, bus.retired_cnt, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("idle_we", 0, 32'(bus.we_w), 32'h0);
    chk("idle_pc", 0, bus.pc_w, 32'h0000_3000);
    chk("idle_cnt", 0, bus.retired_cnt, 32'h0);

    // id, v, bub, pc, we, a3, sel, ld, lo, alu, exp_we, exp_wd, exp_exc
    issue(1,  1, 0, 32'h3004, 1, 5'd5,  2'd0, 3'd0, 2'd0, 32'h1234_5678, 1, 32'h1234_5678, 0);
    issue(2,  1, 0, 32'h3008, 1, 5'd8,  2'd1, 3'd1, 2'd3, 32'h0, 1, 32'hFFFF_FF80, 0);
    issue(3,  1, 0, 32'h300C, 1, 5'd9,  2'd1, 3'd2, 2'd2, 32'h0, 1, 32'h0000_00FF, 0);
    issue(4,  1, 0, 32'h3010, 1, 5'd9,  2'd1, 3'd3, 2'd2, 32'h0, 1, 32'hFFFF_80FF, 0);
    issue(5,  1, 0, 32'h3014, 1, 5'd9,  2'd1, 3'd4, 2'd0, 32'h0, 1, 32'h0000_7F01, 0);
    issue(6,  1, 0, 32'h3018, 1, 5'd10, 2'd1, 3'd0, 2'd2, 32'h0, 0, 32'h80FF_7F01, 1);
    issue(7,  1, 0, 32'h301C, 1, 5'd10, 2'd1, 3'd3, 2'd1, 32'h0, 0, 32'h0000_7F01, 1);
    issue(8,  1, 0, 32'h3020, 1, 5'd11, 2'd1, 3'd0, 2'd0, 32'h0, 1, 32'h80FF_7F01, 0);
    issue(9,  1, 0, 32'h3010, 1, 5'd31, 2'd2, 3'd0, 2'd0, 32'h0, 1, 32'h0000_3018, 0);
    issue(10, 1, 0, 32'hFFFF_FFFC, 1, 5'd31, 2'd2, 3'd0, 2'd0, 32'h0, 1, 32'h0000_0004, 0);
    issue(11, 1, 0, 32'h3024, 1, 5'd0,  2'd0, 3'd0, 2'd0, 32'h0000_DEAD, 0, 32'h0000_DEAD, 0);
    issue(12, 1, 1, 32'h3028, 1, 5'd6,  2'd0, 3'd0, 2'd0, 32'h0000_BEEF, 0, 32'h0, 0);
    issue(13, 1, 0, 32'h302C, 1, 5'd12, 2'd3, 3'd0, 2'd0, 32'h0, 1, 32'hCAFE_BABE, 0);
    issue(14, 1, 0, 32'h3030, 1, 5'd13, 2'd1, 3'd1, 2'd1, 32'h0, 1, 32'h0000_007F, 0);
    nop(15);
    nop(16);

    issue(20, 1, 0, 32'h3040, 1, 5'd7, 2'd0, 3'd0, 2'd0, 32'h0000_0077, 1, 32'h0000_0077, 0);
    @(posedge clk);
    @(negedge clk);
    #2;
    reset       = 1'b1;
    bus.valid_m = 1'b0;
    #1;
    chk("mid_rst_we", 20, 32'(bus.we_w), 32'h0);
    chk("mid_rst_cnt", 20, bus.retired_cnt, 32'h0);
    chk("mid_rst_pc", 20, bus.pc_w, 32'h0000_3000);
    chk("mid_rst_a3", 20, 32'(bus.a3_w), 32'h0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    model_cnt = 32'd0;

    issue(21, 1, 0, 32'h3044, 1, 5'd3, 2'd0, 3'd0, 2'd0, 32'h0000_0033, 1, 32'h0000_0033, 0);
    nop(22);
    nop(23);
    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", 0, 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
